// File: rtl/logic_gate_unit_if.sv
// logic_gate_unit_if: operand/result handshake bus for logic_gate_unit.
//   A, B, OP, IN_VALID  : operands and op select, driven by the producer
//   IN_READY            : unit can accept an operand set this cycle
//   X, OUT_VALID        : registered result and its valid
//   OUT_READY           : consumer accepts X this cycle
//   COUNT               : completed output handshakes (wrapping)
//   X_RAND/X_ROR/X_RXOR : result reductions, present only with LOGIC_GATE_UNIT_REDUCE_EN
// master = producer/consumer side, slave = the unit.
interface logic_gate_unit_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
);
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2:0]           OP;
    logic                 IN_VALID;
    logic                 IN_READY;
    logic [WIDTH-1:0]     X;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [CNT_WIDTH-1:0] COUNT;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic                 X_RAND;
    logic                 X_ROR;
    logic                 X_RXOR;
`endif

    modport master (
        output A, B, OP, IN_VALID, OUT_READY,
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        input  X_RAND, X_ROR, X_RXOR,
`endif
        input  IN_READY, X, OUT_VALID, COUNT
    );

    modport slave (
        input  A, B, OP, IN_VALID, OUT_READY,
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        output X_RAND, X_ROR, X_RXOR,
`endif
        output IN_READY, X, OUT_VALID, COUNT
    );
endinterface

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: 2-stage pipelined bitwise logic unit with valid/ready on both sides.
//   CLK   : clock, rising edge
//   RST_N : synchronous active-low reset
//   bus   : logic_gate_unit_if slave (operands in, result out, completed-transfer COUNT)
// OP: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 PASS A.
// Optional macro LOGIC_GATE_UNIT_REDUCE_EN adds registered X_RAND/X_ROR/X_RXOR.
module logic_gate_unit #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    logic_gate_unit_if.slave    bus
);
    localparam int unsigned OP_W = 3;

    // Stage 1: captured operands
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;

    // Stage 2: registered result
    logic                 out_valid_q;
    logic [WIDTH-1:0]     x_q;
    logic [CNT_WIDTH-1:0] count_q;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    logic                 x_rand_q;
    logic                 x_ror_q;
    logic                 x_rxor_q;
`endif

    logic             s2_free_c;
    logic             s1_move_c;
    logic             in_ready_c;
    logic             in_fire_c;
    logic             out_fire_c;
    logic [WIDTH-1:0] f_c;

    // Pipeline advance: a stage may load when its successor is empty or draining
    assign s2_free_c  = !out_valid_q || bus.OUT_READY;
    assign s1_move_c  = s1_valid && s2_free_c;
    assign in_ready_c = !s1_valid || s1_move_c;
    assign in_fire_c  = bus.IN_VALID && in_ready_c;
    assign out_fire_c = out_valid_q && bus.OUT_READY;

    // Bitwise operation on the stage-1 operands
    always_comb begin
        f_c = '0;
        case (s1_op)
            3'b000:  f_c = s1_a & s1_b;
            3'b001:  f_c = s1_a | s1_b;
            3'b010:  f_c = ~(s1_a & s1_b);
            3'b011:  f_c = ~(s1_a | s1_b);
            3'b100:  f_c = s1_a ^ s1_b;
            3'b101:  f_c = ~(s1_a ^ s1_b);
            3'b110:  f_c = ~s1_a;
            default: f_c = s1_a;
        endcase
    end

    // Stage registers and completion counter
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_op       <= '0;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            count_q     <= '0;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
            x_rand_q    <= 1'b0;
            x_ror_q     <= 1'b0;
            x_rxor_q    <= 1'b0;
`endif
        end else begin
            if (in_fire_c) begin
                s1_valid <= 1'b1;
                s1_a     <= bus.A;
                s1_b     <= bus.B;
                s1_op    <= bus.OP;
            end else if (s1_move_c) begin
                s1_valid <= 1'b0;
            end

            // X keeps its last value when stage 2 empties
            if (s2_free_c) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    x_q      <= f_c;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
                    x_rand_q <= &f_c;
                    x_ror_q  <= |f_c;
                    x_rxor_q <= ^f_c;
`endif
                end
            end

            if (out_fire_c) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.IN_READY  = in_ready_c;
    assign bus.X         = x_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.COUNT     = count_q;
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
    assign bus.X_RAND    = x_rand_q;
    assign bus.X_ROR     = x_ror_q;
    assign bus.X_RXOR    = x_rxor_q;
`endif
endmodule

// File: tb/tb_logic_gate_unit.sv
// tb_logic_gate_unit: table-driven and scoreboard bench for logic_gate_unit (WIDTH=8, CNT_WIDTH=4).
module tb_logic_gate_unit;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [W-1:0] x;
        logic         r_and;
        logic         r_or;
        logic         r_xor;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        exp_t         e;
    } vec_t;

    logic clk;
    logic rst_n;

    logic_gate_unit_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();

    logic_gate_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total;
    int          bad;
    exp_t        sb_q[$];
    exp_t        cur_exp;
    logic [CW-1:0] cnt_model;
    logic        rnd_ready;
    int          last_cyc;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_t r;
        case (op)
            3'd0: r.x = a & b;
            3'd1: r.x = a | b;
            3'd2: r.x = ~(a & b);
            3'd3: r.x = ~(a | b);
            3'd4: r.x = a ^ b;
            3'd5: r.x = ~(a ^ b);
            3'd6: r.x = ~a;
            default: r.x = a;
        endcase
        r.r_and = &r.x;
        r.r_or  = |r.x;
        r.r_xor = ^r.x;
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                cnt_model = '0;
            end else begin
                if (bus.OUT_VALID && bus.OUT_READY) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", 64'(bus.X), 64'hDEAD);
                    end else begin
                        e = sb_q.pop_front();
                        chk("x", 64'(bus.X), 64'(e.x));
`ifdef LOGIC_GATE_UNIT_REDUCE_EN
                        chk("x_rand", 64'(bus.X_RAND), 64'(e.r_and));
                        chk("x_ror",  64'(bus.X_ROR),  64'(e.r_or));
                        chk("x_rxor", 64'(bus.X_RXOR), 64'(e.r_xor));
`endif
                        chk("count_at_pop", 64'(bus.COUNT), 64'(cnt_model));
                        cnt_model = cnt_model + CW'(1);
                    end
                end
                if (bus.IN_VALID && bus.IN_READY) sb_q.push_back(cur_exp);
            end
        end
    endtask

    // Hold the current input until accepted; last_cyc = edges waited
    task automatic wait_accept();
        logic acc;
        acc = 1'b0;
        last_cyc = 0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus.IN_READY;
            @(posedge clk);
            #1;
            last_cyc++;
            if (rnd_ready) bus.OUT_READY = 1'($urandom_range(0, 1));
        end
        if (!acc) chk("accept_timeout", 64'(last_cyc), 64'd0);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input exp_t e);
        bus.A = a;
        bus.B = b;
        bus.OP = op;
        cur_exp = e;
        bus.IN_VALID = 1'b1;
        wait_accept();
    endtask

    task automatic drain();
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.IN_VALID = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t tbl1[8];
    vec_t tbl6[2];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        rnd_ready = 1'b0;
        cnt_model = '0;
        cur_exp = '0;
        rst_n = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.OP = '0;
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b1;

        tbl1[0] = '{a: 8'hF0, b: 8'h3C, op: 3'd0, e: '{x: 8'h30, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b0}};
        tbl1[1] = '{a: 8'hF0, b: 8'h3C, op: 3'd1, e: '{x: 8'hFC, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b0}};
        tbl1[2] = '{a: 8'hF0, b: 8'h3C, op: 3'd2, e: '{x: 8'hCF, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b0}};
        tbl1[3] = '{a: 8'hF0, b: 8'h3C, op: 3'd3, e: '{x: 8'h03, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b0}};
        tbl1[4] = '{a: 8'hF0, b: 8'h3C, op: 3'd4, e: '{x: 8'hCC, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b0}};
        tbl1[5] = '{a: 8'hF0, b: 8'h3C, op: 3'd5, e: '{x: 8'h33, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b0}};
        tbl1[6] = '{a: 8'hF0, b: 8'h3C, op: 3'd6, e: '{x: 8'h0F, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b0}};
        tbl1[7] = '{a: 8'hF0, b: 8'h3C, op: 3'd7, e: '{x: 8'hF0, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b0}};
        tbl6[0] = '{a: 8'hFF, b: 8'h00, op: 3'd7, e: '{x: 8'hFF, r_and: 1'b1, r_or: 1'b1, r_xor: 1'b0}};
        tbl6[1] = '{a: 8'h07, b: 8'h00, op: 3'd7, e: '{x: 8'h07, r_and: 1'b0, r_or: 1'b1, r_xor: 1'b1}};

        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("rst_x", 64'(bus.X), 64'd0);
        chk("rst_count", 64'(bus.COUNT), 64'd0);
        chk("rst_in_ready", 64'(bus.IN_READY), 64'd1);

        // All eight ops back-to-back, plus first-result latency
        for (int i = 0; i < 8; i++) begin
            send(tbl1[i].a, tbl1[i].b, tbl1[i].op, tbl1[i].e);
            chk("t1_accept_cycles", 64'(last_cyc), 64'd1);
            if (i == 0) chk("t1_not_valid_yet", 64'(bus.OUT_VALID), 64'd0);
            if (i == 1) begin
                chk("t1_first_valid", 64'(bus.OUT_VALID), 64'd1);
                chk("t1_first_x", 64'(bus.X), 64'h30);
            end
        end
        drain();
        chk("t1_count", 64'(bus.COUNT), 64'd8);

        // Backpressure: two fill the pipe, the third stalls
        bus.OUT_READY = 1'b0;
        send(8'h00, 8'h00, 3'd3, model(8'h00, 8'h00, 3'd3));
        send(8'h01, 8'h00, 3'd3, model(8'h01, 8'h00, 3'd3));
        bus.A = 8'h02;
        bus.B = 8'h00;
        bus.OP = 3'd3;
        cur_exp = model(8'h02, 8'h00, 3'd3);
        bus.IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_in_ready_low", 64'(bus.IN_READY), 64'd0);
            chk("t2_out_valid", 64'(bus.OUT_VALID), 64'd1);
            chk("t2_x_hold", 64'(bus.X), 64'hFF);
        end
        @(posedge clk);
        #1;
        bus.OUT_READY = 1'b1;
        wait_accept();
        chk("t2_release_accept", 64'(last_cyc), 64'd1);
        drain();
        chk("t2_count", 64'(bus.COUNT), 64'(cnt_model));

        // Both stages full, then accept and drain on the same edges
        bus.OUT_READY = 1'b0;
        send(8'hA5, 8'h5A, 3'd0, model(8'hA5, 8'h5A, 3'd0));
        send(8'hA5, 8'h5A, 3'd1, model(8'hA5, 8'h5A, 3'd1));
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(8'(i * 37), 8'(i * 11 + 3), 3'(i), model(8'(i * 37), 8'(i * 11 + 3), 3'(i)));
            chk("t3_no_bubble", 64'(last_cyc), 64'd1);
            chk("t3_out_valid", 64'(bus.OUT_VALID), 64'd1);
        end
        drain();
        chk("t3_count", 64'(bus.COUNT), 64'(cnt_model));

        // Random backpressure stream
        rnd_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic [2:0]   ro;
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = 3'($urandom);
            send(ra, rb, ro, model(ra, rb, ro));
        end
        rnd_ready = 1'b0;
        drain();
        chk("rand_count", 64'(bus.COUNT), 64'(cnt_model));

        // Reset with two items in flight
        bus.OUT_READY = 1'b0;
        send(8'h11, 8'h22, 3'd1, model(8'h11, 8'h22, 3'd1));
        send(8'h33, 8'h44, 3'd1, model(8'h33, 8'h44, 3'd1));
        do_reset();
        chk("t4_out_valid", 64'(bus.OUT_VALID), 64'd0);
        chk("t4_x", 64'(bus.X), 64'd0);
        chk("t4_count", 64'(bus.COUNT), 64'd0);
        bus.OUT_READY = 1'b1;
        send(8'h5A, 8'h0F, 3'd4, model(8'h5A, 8'h0F, 3'd4));
        bus.IN_VALID = 1'b0;
        chk("t4_latency_n", 64'(bus.OUT_VALID), 64'd0);
        @(posedge clk);
        #1;
        chk("t4_latency_n1", 64'(bus.OUT_VALID), 64'd1);
        chk("t4_x_after", 64'(bus.X), 64'h55);
        drain();
        chk("t4_count_after", 64'(bus.COUNT), 64'd1);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(8'(i), 8'hFF, 3'd4, model(8'(i), 8'hFF, 3'd4));
        end
        drain();
        chk("t5_count_wrap", 64'(bus.COUNT), 64'd1);

`ifdef LOGIC_GATE_UNIT_REDUCE_EN
        // Reduction outputs
        for (int i = 0; i < 2; i++) begin
            send(tbl6[i].a, tbl6[i].b, tbl6[i].op, tbl6[i].e);
        end
        drain();
        chk("t6_x_last", 64'(bus.X), 64'h07);
        chk("t6_rxor_last", 64'(bus.X_RXOR), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_gate_unit.md
Name: logic_gate_unit

Overview:
- Parametrised, pipelined successor to the single-bit combinational gates.
- Applies one of eight bitwise logic operations to two WIDTH-bit operands.
- Runs through a 2-stage registered pipeline with valid/ready handshakes on input and output.
- Counts completed results; serves as the shared logic primitive for datapath blocks in the gates library.

Parameters:
WIDTH, 8, operand and result width in bits (1 to 64)
CNT_WIDTH, 16, width of completed-transaction counter

Ports:
CLK  input  1  clock, all logic on rising edge
RST_N  input  1  reset, synchronous, active-low
A  input  WIDTH  operand A
B  input  WIDTH  operand B
OP  input  3  operation select, sampled with A/B on input handshake
IN_VALID  input  1  A/B/OP valid
IN_READY  output  1  unit can accept A/B/OP this cycle
X  output  WIDTH  registered result
OUT_VALID  output  1  X valid
OUT_READY  input  1  downstream accepts X this cycle
COUNT  output  CNT_WIDTH  number of completed output handshakes

Behaviour:
- Interface: one clock CLK; reset RST_N is synchronous and active-low.
- Reset (RST_N=0 at a rising edge) clears:
  - X=0, OUT_VALID=0, COUNT=0
  - stage-1 valid=0, stage-1 operand/op registers=0
- IN_READY is combinational and is not gated by reset.
- OP encoding, applied bitwise:
  - 000 AND, 001 OR, 010 NAND, 011 NOR
  - 100 XOR, 101 XNOR
  - 110 NOT A (B ignored), 111 PASS A (B ignored)
- Handshakes:
  - Input transfer occurs when IN_VALID & IN_READY at a rising edge.
  - Output transfer occurs when OUT_VALID & OUT_READY at a rising edge.
- Stage 1 (s1):
  - Registers A, B, OP on input transfer; sets s1_valid.
- Stage 2 (s2):
  - Computes f(OP) on the s1 registers and loads X; OUT_VALID = s2_valid.
- Advance rules, all combinational:
  - s2_free = !OUT_VALID | OUT_READY
  - s1_move = s1_valid & s2_free
  - IN_READY = !s1_valid | s1_move
- Register updates:
  - s2 loads when s2_free. If s1_valid, s2_valid becomes 1 with the new X; otherwise s2_valid becomes 0 and X holds its last value.
  - s1 loads on input transfer. If s1_move occurs without an input transfer, s1_valid clears.
- Latency and throughput:
  - Input transfer at edge N gives OUT_VALID=1 after edge N+1 (2-cycle latency).
  - Throughput is 1 result per cycle with OUT_READY held high.
- Backpressure:
  - While OUT_VALID=1 and OUT_READY=0, X and OUT_VALID hold stable.
  - s1 can still fill; IN_READY drops once s1 is full.
  - Maximum 2 results in flight; no data is lost or duplicated.
- A new input and an output drain on the same edge with both stages full are legal and lossless.
- COUNT increments by 1 on each output transfer and wraps from all-ones to 0.
- Reset mid-operation discards in-flight data. The first edge after RST_N returns high behaves as an empty pipeline.
- Inputs are not checked when IN_VALID=0. OP values are all defined, so there is no illegal-op case.

Optional Feature:
- Macro: LOGIC_GATE_UNIT_REDUCE_EN.
- When defined, three extra output ports are added:
  - X_RAND (1): reduction-AND of X
  - X_ROR (1): reduction-OR of X
  - X_RXOR (1): reduction-XOR (parity) of X
- The reduction outputs are registered in stage 2 alongside X and follow the same hold/stall rules.
- They reset to 0 and are valid only when OUT_VALID=1.
- When the macro is not defined, these ports and their registers are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=8, OUT_READY=1: send A=8'hF0, B=8'h3C for OP=000..111 back-to-back -> X sequence 30, FC, CF, 03, CC, 33, 0F, F0. First OUT_VALID two edges after the first input transfer; COUNT=8 at end.
2. Backpressure:
   - Hold OUT_READY=0 and issue 3 inputs (OP=011, A=00, B=00 / A=01 / A=02) -> IN_READY falls after 2 transfers, X=8'hFF held stable.
   - Then raise OUT_READY -> outputs FF, FE, FD in order, none dropped.
3. Simultaneous accept and drain with both stages full -> no bubble, no loss; COUNT matches the number of outputs accepted.
4. Reset mid-stream:
   - Assert RST_N=0 for one edge with 2 items in flight -> OUT_VALID=0, X=0, COUNT=0.
   - Next input yields its result 2 edges later.
5. COUNT wrap with CNT_WIDTH=4: 17 completed outputs -> COUNT=1.
6. With LOGIC_GATE_UNIT_REDUCE_EN, OP=111, A=8'hFF then 8'h07 -> (X_RAND, X_ROR, X_RXOR) = (1,1,0) then (0,1,1).
